window3x3_assembler: RTL

Consumes three row-aligned pixel streams: the current row plus the one-line and two-line delayed outputs of the line delay buffers. Assembles them into a 3x3 neighbourhood window for the Sobel kernel, emitting one window per interior pixel over a valid/ready stream. Sits between the line delay buffers and the gradient datapath, and is the read-side consumer of the delayed-row streams.

---
 rtl/sobel_pkg.sv | 18 +
 rtl/window3x3_assembler_counter.sv | 40 ++++
 rtl/window3x3_assembler.sv | 131 +++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel pipeline.
//   WIN_DIM_C / WIN_PIX_C : window edge length and pixel count
//   window_t              : packed 3x3 window at the default pixel width
//   win_idx(r,c,w)        : bit offset of p[r][c] in a packed window of
//                           w-bit pixels (r=0 top row, c=0 oldest column)
package sobel_pkg;

  localparam int WIN_DIM_C = 3;
  localparam int WIN_PIX_C = 9;
  localparam int PIX_W_C   = 8;

  typedef logic [WIN_PIX_C*PIX_W_C-1:0] window_t;

  function automatic int win_idx(input int r, input int c, input int w);
    return (WIN_DIM_C*r + c) * w;
  endfunction

endpackage

// File: rtl/window3x3_assembler_counter.sv
// Wrapping/saturating up-counter.
//   clk_i   : clock (rising edge)
//   rstn_i  : synchronous active-low reset, clears the count
//   en_i    : count enable
//   max_i   : terminal count
//   count_o : current count
//   wrap_o  : en_i while at max_i (count returns to 0 on this edge);
//             never asserted in saturating mode
module window3x3_assembler_counter #(
  parameter int WIDTH_P    = 4,
  parameter bit SATURATE_P = 1'b0
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               en_i,
  input  logic [WIDTH_P-1:0] max_i,
  output logic [WIDTH_P-1:0] count_o,
  output logic               wrap_o
);

  logic [WIDTH_P-1:0] r_count;
  logic               w_at_max;

  assign w_at_max = (r_count == max_i);
  assign wrap_o   = en_i & w_at_max & ~SATURATE_P;
  assign count_o  = r_count;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_count <= '0;
    end else if (en_i) begin
      if (w_at_max) begin
        r_count <= SATURATE_P ? r_count : '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/window3x3_assembler.sv
// 3x3 window assembler for the Sobel kernel.
// Takes a column of three row-aligned pixels per accept (current line and
// the one- and two-line delayed lines), keeps a 3-column shift array and
// emits one window per interior pixel on a registered valid/ready stream.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   valid_i / ready_o  : input column handshake
//   row0_i/row1_i/row2_i : bottom / middle / top pixel of the new column
//   valid_o / ready_i  : output window handshake
//   window_o           : p[r][c] at bits [(3*r+c)*WIDTH_P +: WIDTH_P]
//   eol_o, last_o      : window closes its line / its frame
module window3x3_assembler
  import sobel_pkg::*;
#(
  parameter int WIDTH_P = 8,
  parameter int COLS_P  = 640,
  parameter int ROWS_P  = 480
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [WIDTH_P-1:0]           row0_i,
  input  logic [WIDTH_P-1:0]           row1_i,
  input  logic [WIDTH_P-1:0]           row2_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [WIN_PIX_C*WIDTH_P-1:0] window_o,
  output logic                         eol_o,
  output logic                         last_o
);

  localparam int CW_C  = $clog2(COLS_P);
  localparam int RW_C  = $clog2(ROWS_P);
  localparam int WIN_W = WIN_PIX_C * WIDTH_P;

  localparam logic [CW_C-1:0] COL_MAX_C = CW_C'(COLS_P - 1);
  localparam logic [RW_C-1:0] ROW_MAX_C = RW_C'(ROWS_P - 1);

  logic             w_accept;
  logic             w_emit;
  logic             w_eol;
  logic             w_last;
  logic             w_col_wrap;
  logic             w_row_wrap;
  logic [CW_C-1:0]  w_col;
  logic [RW_C-1:0]  w_row;
  logic [WIN_W-1:0] w_arr_nxt;

  logic [WIN_W-1:0] r_arr;
  logic             r_valid;
  logic [WIN_W-1:0] r_window;
  logic             r_eol;
  logic             r_last;

  // A full output register only blocks when downstream is stalled.
  assign ready_o  = ~r_valid | ready_i;
  assign w_accept = valid_i & ready_o;

  window3x3_assembler_counter #(
    .WIDTH_P    (CW_C),
    .SATURATE_P (1'b0)
  ) u_col_cnt (
    .clk_i   (clk_i),
    .rstn_i  (~rst_i),
    .en_i    (w_accept),
    .max_i   (COL_MAX_C),
    .count_o (w_col),
    .wrap_o  (w_col_wrap)
  );

  window3x3_assembler_counter #(
    .WIDTH_P    (RW_C),
    .SATURATE_P (1'b0)
  ) u_row_cnt (
    .clk_i   (clk_i),
    .rstn_i  (~rst_i),
    .en_i    (w_col_wrap),
    .max_i   (ROW_MAX_C),
    .count_o (w_row),
    .wrap_o  (w_row_wrap)
  );

  // Flags describe the pixel being accepted, i.e. the counters before
  // they advance on this edge.
  assign w_emit = w_accept & (w_col >= CW_C'(2)) & (w_row >= RW_C'(2));
  assign w_eol  = (w_col == COL_MAX_C);
  assign w_last = w_eol & (w_row == ROW_MAX_C);

  // Next array: shift every row one column towards c=0 and drop the new
  // column into c=2. Window row 0 is the oldest line (row2_i).
  always_comb begin
    w_arr_nxt = r_arr;
    for (int r = 0; r < WIN_DIM_C; r++) begin
      for (int c = 0; c < WIN_DIM_C - 1; c++) begin
        w_arr_nxt[win_idx(r, c, WIDTH_P) +: WIDTH_P] =
          r_arr[win_idx(r, c + 1, WIDTH_P) +: WIDTH_P];
      end
    end
    w_arr_nxt[win_idx(0, 2, WIDTH_P) +: WIDTH_P] = row2_i;
    w_arr_nxt[win_idx(1, 2, WIDTH_P) +: WIDTH_P] = row1_i;
    w_arr_nxt[win_idx(2, 2, WIDTH_P) +: WIDTH_P] = row0_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_arr    <= '0;
      r_valid  <= 1'b0;
      r_window <= '0;
      r_eol    <= 1'b0;
      r_last   <= 1'b0;
    end else if (w_accept) begin
      r_arr <= w_arr_nxt;
      if (w_emit) begin
        r_valid  <= 1'b1;
        r_window <= w_arr_nxt;
        r_eol    <= w_eol;
        r_last   <= w_last;
      end else begin
        r_valid <= 1'b0;
      end
    end else if (ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign valid_o  = r_valid;
  assign window_o = r_window;
  assign eol_o    = r_eol;
  assign last_o   = r_last;

endmodule
